calc_op_sequencer: RTL and testbench

- Sequences the calculator's single shared N-bit carry-lookahead adder to perform all four operations: add, subtract, unsigned multiply and unsigned divide.
- Add and subtract take one adder pass.
- Multiply uses iterative shift-add; divide uses iterative restoring division, with N adder passes each.
- Sits between the keypad/operand registers and the shared adder. It drives the adder operands and carry-in, and consumes the adder's sum and carry-out.

---
 rtl/calc_op_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: drives one shared N-bit adder to perform add, subtract,
// unsigned shift-add multiply and unsigned restoring divide. Add/sub take a
// single adder pass; mul/div take N passes, one per clock.
module calc_op_sequencer #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_cout,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           div0
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [1:0]    op_reg;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] count;

  // Restoring-division view of the partial remainder: shift in the next
  // dividend bit; the bit shifted out of hi is kept as an overflow flag so a
  // remainder that momentarily exceeds N bits still subtracts correctly.
  logic [N-1:0] div_r;
  logic         div_ov;
  logic         div_q;
  logic [N-1:0] div_hi_next;
  logic [N-1:0] div_lo_next;
  logic [N-1:0] mul_hi_next;
  logic [N-1:0] mul_lo_next;
  logic         last_iter;

  assign div_r       = {hi[N-2:0], lo[N-1]};
  assign div_ov      = hi[N-1];
  assign div_q       = div_ov | add_cout;
  assign div_hi_next = div_q ? add_sum : div_r;
  assign div_lo_next = {lo[N-2:0], div_q};

  // Multiply: {cout, sum, lo} shifted right by one, split back into hi/lo.
  assign mul_hi_next = {add_cout, add_sum[N-1:1]};
  assign mul_lo_next = {add_sum[0], lo[N-1:1]};

  assign last_iter   = (count == CW'(N - 1));

  // Adder operand selection, purely a function of the current state so the
  // adder is idle (all zeros) outside the arithmetic states.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_ADDSUB: begin
        add_a = a_reg;
        if (op_reg == OP_SUB) begin
          add_b   = ~b_reg;
          add_cin = 1'b1;
        end else begin
          add_b   = b_reg;
        end
      end
      S_MUL: begin
        add_a = hi;
        add_b = lo[0] ? a_reg : '0;
      end
      S_DIV: begin
        add_a   = div_r;
        add_b   = ~b_reg;
        add_cin = 1'b1;
      end
      default: begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      result <= '0;
      carry  <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            carry  <= 1'b0;
            div0   <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            case (op)
              OP_ADD, OP_SUB: begin
                state <= S_ADDSUB;
              end
              OP_MUL: begin
                hi    <= '0;
                lo    <= b;
                state <= S_MUL;
              end
              default: begin
                if (b == '0) begin
                  // Divide by zero: skip the iterations entirely.
                  div0   <= 1'b1;
                  result <= '0;
                  done   <= 1'b1;
                  state  <= S_DONE;
                end else begin
                  hi    <= '0;
                  lo    <= a;
                  state <= S_DIV;
                end
              end
            endcase
          end
        end

        S_ADDSUB: begin
          result <= {{N{1'b0}}, add_sum};
          // For subtraction the adder carry is the inverted borrow.
          carry  <= (op_reg == OP_SUB) ? ~add_cout : add_cout;
          done   <= 1'b1;
          state  <= S_DONE;
        end

        S_MUL: begin
          hi    <= mul_hi_next;
          lo    <= mul_lo_next;
          count <= count + CW'(1);
          if (last_iter) begin
            result <= {mul_hi_next, mul_lo_next};
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DIV: begin
          hi    <= div_hi_next;
          lo    <= div_lo_next;
          count <= count + CW'(1);
          if (last_iter) begin
            result <= {div_hi_next, div_lo_next};
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer: models the shared adder, issues directed
// and random operations, and checks completions through a scoreboard queue
// against arithmetic reference results.
module tb_calc_op_sequencer;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     op;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_cin;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  logic           busy;
  logic           done;
  logic [2*N-1:0] result;
  logic           carry;
  logic           div0;

  calc_op_sequencer #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .div0     (div0)
  );

  // Shared adder behaviour: plain N+1-bit addition.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        d0;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   s;
    e.op = o; e.a = x; e.b = y;
    e.res = '0; e.c = 1'b0; e.d0 = 1'b0; e.lat = 0; e.start_cyc = 0;
    case (o)
      2'd0: begin
        s = int'(x) + int'(y);
        e.res = 16'(s % 256);
        e.c = (s > 255);
        e.lat = 2;
      end
      2'd1: begin
        s = int'(x) - int'(y) + 256;
        e.res = 16'(s % 256);
        e.c = (x < y);
        e.lat = 2;
      end
      2'd2: begin
        e.res = 16'(int'(x) * int'(y));
        e.lat = N + 1;
      end
      default: begin
        if (y == 0) begin
          e.d0 = 1'b1;
          e.lat = 1;
        end else begin
          e.res = 16'((int'(x) % int'(y)) * 256 + int'(x) / int'(y));
          e.lat = N + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse and verifies the held
  // result one cycle later.
  initial begin
    int          busy_len;
    bit          hold_pending;
    logic [15:0] held_res;
    exp_t        e;
    busy_len = 0;
    hold_pending = 0;
    held_res = '0;
    forever begin
      @(negedge clk);
      if (hold_pending && !reset) chk("result_hold", result, held_res);
      hold_pending = 0;
      if (reset || !busy) busy_len = 0;
      else busy_len++;
      if (done && !reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("op=%0d a=%0d b=%0d -> result=%04h carry=%0b div0=%0b latency=%0d",
                   e.op, e.a, e.b, result, carry, div0, cyc - e.start_cyc);
          chk("result", result, e.res);
          chk("carry", carry, e.c);
          chk("div0", div0, e.d0);
          chk("latency", cyc - e.start_cyc, e.lat);
          chk("busy_cycles", busy_len, e.lat);
          hold_pending = 1;
          held_res = e.res;
        end
      end
    end
  end

  // Issue one operation once the DUT is idle; optionally hammer start with
  // random operands while busy and during the done cycle.
  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input bit push, input bit noisy);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) chk("idle_timeout", 1, 0);
    e = model(o, x, y);
    e.start_cyc = cyc;
    if (push) exp_q.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (noisy) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); start = 1'b1;
        if (done) begin
          @(posedge clk);
          #1 start = 1'b0;
          break;
        end
      end
      start = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    reset = 1'b0;

    // Directed cases.
    issue(2'd0, 8'd200, 8'd100, 1, 0);

    // Abort a multiply during its 4th iteration with async reset.
    issue(2'd2, 8'd123, 8'd45, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_result", result, 0);
    chk("abort_carry", carry, 0);
    chk("abort_div0", div0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_add_a", add_a, 0);
    chk("abort_add_b", add_b, 0);
    chk("abort_add_cin", add_cin, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_idle_busy", busy, 0);

    issue(2'd1, 8'd5,   8'd9,   1, 0);
    issue(2'd1, 8'd9,   8'd5,   1, 0);
    issue(2'd2, 8'd255, 8'd255, 1, 1);
    issue(2'd2, 8'd0,   8'd77,  1, 0);
    issue(2'd3, 8'd200, 8'd7,   1, 1);
    issue(2'd3, 8'd255, 8'd1,   1, 0);
    issue(2'd3, 8'd3,   8'd200, 1, 0);
    issue(2'd3, 8'd37,  8'd0,   1, 1);
    issue(2'd0, 8'd1,   8'd1,   1, 0);
    issue(2'd0, 8'd255, 8'd1,   1, 1);

    // Random operations, including occasional zero divisors.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(ro, ra, rb, 1, bit'($urandom_range(0, 1)));
    end

    repeat (20) @(negedge clk);
    chk("final_busy", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
